decoder_sel_pipe: RTL



---
 rtl/decoder_sel_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/decoder_sel_pipe.sv
// Registered one-hot select decoder with valid/ready handshake and a reset-time sweep mode.
// Optional build macro ZERO_MASK_EN: index 0 decodes to all-zero and the sweep starts at index 1.
module decoder_sel_pipe #(
    parameter int SEL_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    in_ready,
    input  logic                    clear_req,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [(2**SEL_W)-1:0]   out,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    busy
);

    localparam int OUT_W = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = {SEL_W{1'b1}};
`ifdef ZERO_MASK_EN
    localparam logic [SEL_W-1:0] FIRST_IDX = {{(SEL_W-1){1'b0}}, 1'b1};
`else
    localparam logic [SEL_W-1:0] FIRST_IDX = {SEL_W{1'b0}};
`endif

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [SEL_W-1:0]   out_sel_q, out_sel_d;
    logic               can_load_s;
    logic               accept_s;

    function automatic logic [OUT_W-1:0] decode_onehot(input logic [SEL_W-1:0] sel);
        logic [OUT_W-1:0] word;
        word = {{(OUT_W-1){1'b0}}, 1'b1} << sel;
`ifdef ZERO_MASK_EN
        word = (sel == {SEL_W{1'b0}}) ? {OUT_W{1'b0}} : word;
`endif
        return word;
    endfunction

    // Handshake qualifiers; in_ready is forced low while reset is held.
    always_comb begin
        can_load_s = !out_valid_q || out_ready;
        in_ready   = rst_n && (state_q == IDLE) && !clear_req && can_load_s;
        accept_s   = in_valid && in_ready;
    end

    // Next-state logic for the FSM, sweep counter and single-entry output stage.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_sel_d   = out_sel_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = SWEEP;
                    cnt_d   = FIRST_IDX;
                end else if (accept_s) begin
                    out_d       = decode_onehot(in_sel);
                    out_sel_d   = in_sel;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                if (can_load_s) begin
                    out_d       = decode_onehot(cnt_q);
                    out_sel_d   = cnt_q;
                    out_valid_d = 1'b1;
                    // The last index ends the sweep so the counter never wraps.
                    if (cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                        cnt_d   = {SEL_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + {{(SEL_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = SWEEP;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = {SEL_W{1'b0}};
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {SEL_W{1'b0}};
            out_valid_q <= 1'b0;
            out_q       <= {OUT_W{1'b0}};
            out_sel_q   <= {SEL_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_sel   = out_sel_q;
    assign busy      = (state_q == SWEEP);

endmodule
